// File: rtl/rem_operand_ctrl.sv
// Operand-entry and result-capture controller for a combinational rem unit.
// Operands arrive serially on load rising edges; the result is captured after a fixed settle time.
module rem_operand_ctrl #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic [WIDTH-1:0] rem_in,
  input  logic             divbyzero_in,
  output logic [WIDTH-1:0] numerator,
  output logic [WIDTH-1:0] denominator,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             result_valid,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DEN = 2'd1,
    SETTLE   = 2'd2,
    SHOW     = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic             load_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] res_q;
  logic             err_q;
  logic             valid_q;
  logic             done_q;
  logic             load_rise_s;

  assign load_rise_s = load & ~load_q;

  // Operand entry, settle timing and result capture; clr aborts, rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b1;
      cnt_q   <= 4'd0;
      num_q   <= '0;
      den_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q <= load;
      done_q <= 1'b0;
      if (clr) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        num_q   <= '0;
        den_q   <= '0;
        res_q   <= '0;
        err_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_rise_s) begin
              num_q   <= data_in;
              valid_q <= 1'b0;
              state_q <= WAIT_DEN;
            end
          end
          WAIT_DEN: begin
            if (load_rise_s) begin
              den_q   <= data_in;
              cnt_q   <= 4'd0;
              state_q <= SETTLE;
            end
          end
          SETTLE: begin
            // Load edges seen here are dropped on purpose so operands stay stable.
            if (cnt_q == CNT_LAST) begin
              res_q   <= rem_in;
              err_q   <= divbyzero_in;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= SHOW;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          SHOW: begin
            if (load_rise_s) begin
              num_q   <= data_in;
              valid_q <= 1'b0;
              state_q <= WAIT_DEN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign numerator    = num_q;
  assign denominator  = den_q;
  assign result       = res_q;
  assign err          = err_q;
  assign result_valid = valid_q;
  assign done         = done_q;
  assign busy         = (state_q == SETTLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_rem_operand_ctrl.sv
// Self-checking bench for rem_operand_ctrl with a behavioural rem unit and reference model.
module tb_rem_operand_ctrl;

  localparam int W  = 3;
  localparam int SC = 2;

  logic         clk = 1'b0;
  logic         rst, clr, load, divbyzero_in;
  logic [W-1:0] data_in, rem_in;
  logic [W-1:0] numerator, denominator, result;
  logic         err, result_valid, done, busy;
  logic [1:0]   state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rem_operand_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .load(load),
    .rem_in(rem_in), .divbyzero_in(divbyzero_in),
    .numerator(numerator), .denominator(denominator), .result(result),
    .err(err), .result_valid(result_valid), .done(done), .busy(busy),
    .state_o(state_o)
  );

  // Rem unit: top bit passes numerator sign, low bits are the unsigned remainder.
  function automatic logic [W-1:0] rem_fn(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [1:0] lo;
    if (d[1:0] != 2'b00) lo = 2'(int'(n[1:0]) % int'(d[1:0]));
    else                 lo = n[1:0];
    return {n[2], lo};
  endfunction

  assign rem_in       = rem_fn(numerator, denominator);
  assign divbyzero_in = (denominator[1:0] == 2'b00);

  // Reference model: phase plus absolute capture time.
  int           edge_no = 0;
  int           cap_at  = -1;
  int           m_phase = 0;
  bit           m_prev  = 1'b1;
  logic [W-1:0] m_num = '0, m_den = '0, m_res = '0;
  bit           m_err = 1'b0, m_rv = 1'b0, m_done = 1'b0;

  task automatic model_edge();
    bit rise;
    rise = load && !m_prev;
    edge_no++;
    m_done = 1'b0;
    if (rst) begin
      m_prev = 1'b1; m_phase = 0; cap_at = -1;
      m_num = '0; m_den = '0; m_res = '0; m_err = 1'b0; m_rv = 1'b0;
    end else begin
      m_prev = load;
      if (clr) begin
        m_phase = 0; cap_at = -1;
        m_num = '0; m_den = '0; m_res = '0; m_err = 1'b0; m_rv = 1'b0;
      end else if (m_phase == 0 || m_phase == 3) begin
        if (rise) begin m_num = data_in; m_rv = 1'b0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (rise) begin m_den = data_in; m_phase = 2; cap_at = edge_no + SC; end
      end else if (edge_no == cap_at) begin
        m_res = rem_fn(m_num, m_den);
        m_err = (m_den[1:0] == 2'b00);
        m_rv = 1'b1; m_done = 1'b1; m_phase = 3;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", int'(state_o), m_phase);
    chk("numerator", int'(numerator), int'(m_num));
    chk("denominator", int'(denominator), int'(m_den));
    chk("result", int'(result), int'(m_res));
    chk("err", int'(err), int'(m_err));
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("done", int'(done), int'(m_done));
    chk("busy", int'(busy), int'(m_phase == 2));
  endtask

  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d);
    load = 1'b0; step();
    data_in = n; load = 1'b1; step();
    load = 1'b0; step();
    data_in = d; load = 1'b1; step();
    load = 1'b0;
    for (int i = 0; i < SC + 1; i++) step();
  endtask

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] exp_res;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy_cnt, done_cnt;
    vecs[0] = '{3'b101, 3'b011, 3'b101, 1'b0};
    vecs[1] = '{3'b110, 3'b100, 3'b110, 1'b1};
    vecs[2] = '{3'b111, 3'b010, 3'b101, 1'b0};
    vecs[3] = '{3'b011, 3'b011, 3'b000, 1'b0};
    vecs[4] = '{3'b010, 3'b011, 3'b010, 1'b0};
    vecs[5] = '{3'b001, 3'b000, 3'b001, 1'b1};

    rst = 1'b1; clr = 1'b0; load = 1'b1; data_in = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    chk("hold_high_state", int'(state_o), 0);
    chk("hold_high_num", int'(numerator), 0);
    load = 1'b0; step();
    data_in = 3'b101; load = 1'b1; step();
    chk("first_num", int'(numerator), 5);
    chk("first_state", int'(state_o), 1);

    // Denominator edge, then count busy and done over the settle window.
    load = 1'b0; step();
    data_in = 3'b011; load = 1'b1; step();
    load = 1'b0;
    busy_cnt = int'(busy); done_cnt = int'(done);
    for (int i = 0; i < 4; i++) begin
      step();
      busy_cnt += int'(busy); done_cnt += int'(done);
      if (i == SC - 2) chk("done_not_early", int'(done), 0);
      if (i == SC - 1) chk("done_on_time", int'(done), 1);
    end
    chk("busy_cycles", busy_cnt, SC);
    chk("done_pulses", done_cnt, 1);
    chk("res_lo_5_3", int'(result[1:0]), 1);
    chk("rv_5_3", int'(result_valid), 1);

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].num, vecs[v].den);
      chk("vec_result", int'(result), int'(vecs[v].exp_res));
      chk("vec_err", int'(err), int'(vecs[v].exp_err));
      chk("vec_valid", int'(result_valid), 1);
    end

    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        run_op(3'(n), 3'(d));
        if ((d % 4) != 0) chk("sweep_rem", int'(result[1:0]), (n % 4) % (d % 4));
        else              chk("sweep_err", int'(err), 1);
      end
    end

    // Load edge during SETTLE is dropped.
    load = 1'b0; step();
    data_in = 3'b101; load = 1'b1; step();
    load = 1'b0; step();
    data_in = 3'b011; load = 1'b1; step();
    load = 1'b0; step();
    data_in = 3'b111; load = 1'b1; step();
    chk("settle_num_kept", int'(numerator), 5);
    chk("settle_den_kept", int'(denominator), 3);
    chk("settle_to_show", int'(state_o), 3);
    load = 1'b0; step();
    data_in = 3'b001; load = 1'b1; step();
    chk("show_load_num", int'(numerator), 1);
    chk("show_load_rv", int'(result_valid), 0);

    // clr together with load edge in WAIT_DEN.
    load = 1'b0; step();
    data_in = 3'b110; load = 1'b1; clr = 1'b1; step();
    clr = 1'b0;
    chk("clr_state", int'(state_o), 0);
    chk("clr_den", int'(denominator), 0);
    chk("clr_num", int'(numerator), 0);

    // rst mid-SETTLE.
    load = 1'b0; step();
    data_in = 3'b101; load = 1'b1; step();
    load = 1'b0; step();
    data_in = 3'b011; load = 1'b1; step();
    rst = 1'b1; step();
    chk("rst_done", int'(done), 0);
    chk("rst_state", int'(state_o), 0);
    rst = 1'b0; load = 1'b0;
    repeat (3) step();
    chk("rst_no_late_done", int'(done), 0);

    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      clr     = ($urandom_range(0, 39) == 0);
      load    = 1'($urandom_range(0, 1));
      data_in = 3'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rem_operand_ctrl.md
Name: rem_operand_ctrl

Overview:
Operand-entry and result-capture controller that sits directly upstream of the combinational rem unit. It accepts numerator and denominator one after the other from a shared 3-bit input bus on rising edges of a load strobe. It holds both operands stable on the rem inputs and waits a programmable settle time. It then registers the rem unit's remainder and divide-by-zero flag and presents them with a valid/done handshake.

Parameters:
WIDTH, 3, operand/result width; must match the rem unit.
SETTLE_CYCLES, 2, cycles from denominator capture to result capture; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous abort; returns the block to IDLE.
data_in  input  WIDTH  operand bus; sampled only on a detected load edge.
load  input  1  operand strobe; only its rising edge acts.
rem_in  input  WIDTH  remainder from the rem unit.
divbyzero_in  input  1  divide-by-zero flag from the rem unit.
numerator  output  WIDTH  registered operand to the rem unit.
denominator  output  WIDTH  registered operand to the rem unit.
result  output  WIDTH  captured remainder.
err  output  1  captured divide-by-zero flag.
result_valid  output  1  result/err hold a completed operation.
done  output  1  one-cycle pulse on the capture cycle.
busy  output  1  high while in SETTLE.
state_o  output  2  current state encoding, for debug.

Behaviour:
- Reset (rst=1 at an edge): numerator=0, denominator=0, result=0, err=0, result_valid=0, done=0, busy=0, state=IDLE (2'd0), settle counter=0, load_q=1.
- Edge detect: load_rise = load & ~load_q; load_q <= load every cycle.
  - load_q resets to 1, so a load held high across reset release is not an edge.
  - Holding load high yields exactly one event.
- States: IDLE=0, WAIT_DEN=1, SETTLE=2, SHOW=3.
- IDLE:
  - On load_rise: numerator <= data_in, result_valid <= 0, go to WAIT_DEN.
  - Otherwise hold.
- WAIT_DEN:
  - On load_rise: denominator <= data_in, cnt <= 0, go to SETTLE.
- SETTLE:
  - busy=1 (combinational from state).
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1: result <= rem_in, err <= divbyzero_in, result_valid <= 1, done <= 1 for that one cycle, go to SHOW.
  - load_rise is ignored in SETTLE. The edge is consumed; it is not queued.
- SHOW:
  - result, err and result_valid hold.
  - On load_rise: numerator <= data_in, result_valid <= 0, err holds, go to WAIT_DEN.
- Latency: denominator load edge sampled at edge k -> capture at edge k+SETTLE_CYCLES. result_valid and done are visible after that edge.
- done is registered. It is 0 on every cycle except the one following the capture edge.
- Operands never change outside the load-edge cycles listed above. The rem inputs are glitch-free during SETTLE.
- The result is captured even when divbyzero_in=1. result then carries whatever rem drives (the rem unit passes numerator[WIDTH-1] on bit WIDTH-1). err=1 marks it invalid as a remainder.
- clr=1 at an edge:
  - state <= IDLE, result_valid <= 0, done <= 0, cnt <= 0.
  - numerator, denominator, result and err are cleared to 0.
  - clr has priority over load_rise in the same cycle; load_q still updates.
- rst has priority over clr. rst mid-SETTLE aborts with no done pulse.
- No arithmetic is performed here. The counter is 4 bits and never wraps, because it is reset on SETTLE entry and exits at SETTLE_CYCLES-1.

Test Plan:
- Reset release with load held high, then 5 idle cycles -> state_o=0, all outputs 0, no operand captured. Drop load and raise it with data_in=3'b101 -> numerator=3'b101, state_o=1.
- numerator=3'b101, then denominator=3'b011, real rem instance connected, SETTLE_CYCLES=2 -> busy high 2 cycles. done pulses exactly once, 2 edges after the denominator edge. result[1:0]=2'b01, err=0, result_valid=1.
- numerator=3'b110, denominator=3'b100 -> err=1, result[2]=1, result_valid=1.
- Exhaustive sweep, all 64 numerator/denominator pairs, through the controller -> result[1:0] equals numerator[1:0] % denominator[1:0] whenever denominator[1:0]!=0. Otherwise err=1.
- load pulse during SETTLE with data_in=3'b111 -> operands unchanged, capture timing unchanged, state reaches SHOW. A next load in SHOW loads numerator and clears result_valid.
- clr and load_rise asserted together in WAIT_DEN -> state_o=0, all registers 0, denominator not loaded. rst asserted mid-SETTLE -> no done pulse, reset values on the next cycle.
